// File: rtl/mpc_wbuf.sv
// Multi-channel store write buffer: round-robin allocation, registered readout, explicit release.
// Optional MPC_WBUF_ERR_EN adds err_o flagging release/read of a non-busy entry.
module mpc_wbuf #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 128,
    parameter int DEPTH    = 32,
    parameter int ID_W     = $clog2(DEPTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [CHANNELS-1:0]        alloc_valid_i,
    input  logic [CHANNELS*DATA_W-1:0] alloc_wdata_i,
    output logic [CHANNELS-1:0]        alloc_ready_o,
    output logic [ID_W-1:0]            alloc_id_o,
    input  logic                       rd_valid_i,
    input  logic [ID_W-1:0]            rd_id_i,
    output logic                       rd_valid_o,
    output logic [DATA_W-1:0]          rd_data_o,
    input  logic                       rel_valid_i,
    input  logic [ID_W-1:0]            rel_id_i,
    output logic [ID_W:0]              free_cnt_o,
    output logic                       full_o
`ifdef MPC_WBUF_ERR_EN
    ,
    output logic                       err_o
`endif
);

    localparam int RR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [DEPTH-1:0]  r_busy;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [RR_W-1:0]   r_rr;

    logic              w_any;
    logic [RR_W-1:0]   w_winner;
    logic              w_grant;
    logic              w_rel;
    logic [ID_W-1:0]   w_free_id;
    logic [DATA_W-1:0] w_wdata;

    // Scan channels starting at the round-robin pointer, wrapping around.
    always_comb begin
        int j;
        j        = 0;
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            j = int'(r_rr) + k;
            if (j >= CHANNELS) j = j - CHANNELS;
            if (!w_any && alloc_valid_i[j[RR_W-1:0]]) begin
                w_any    = 1'b1;
                w_winner = j[RR_W-1:0];
            end
        end
    end

    always_comb begin
        w_free_id = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_id = i[ID_W-1:0];
        end
    end

    assign full_o        = (free_cnt_o == '0);
    assign w_grant       = w_any && !full_o;
    assign w_rel         = rel_valid_i && r_busy[rel_id_i];
    assign alloc_ready_o = w_grant ? (CHANNELS'(1) << w_winner) : '0;
    assign alloc_id_o    = w_free_id;
    assign w_wdata       = alloc_wdata_i[w_winner*DATA_W +: DATA_W];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy     <= '0;
            r_rr       <= '0;
            free_cnt_o <= (ID_W+1)'(DEPTH);
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            if (w_grant) begin
                r_busy[w_free_id] <= 1'b1;
                if (w_winner == RR_W'(CHANNELS - 1)) r_rr <= '0;
                else r_rr <= w_winner + 1'b1;
            end
            if (w_rel) r_busy[rel_id_i] <= 1'b0;
            unique case ({w_grant, w_rel})
                2'b10:   free_cnt_o <= free_cnt_o - (ID_W+1)'(1);
                2'b01:   free_cnt_o <= free_cnt_o + (ID_W+1)'(1);
                default: free_cnt_o <= free_cnt_o;
            endcase
            rd_valid_o <= rd_valid_i;
            if (rd_valid_i) rd_data_o <= r_data[rd_id_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_grant) r_data[w_free_id] <= w_wdata;
    end

`ifdef MPC_WBUF_ERR_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_o <= 1'b0;
        else err_o <= (rel_valid_i && !r_busy[rel_id_i])
                   || (rd_valid_i && !r_busy[rd_id_i]);
    end
`endif

endmodule

// File: doc/mpc_wbuf.md
Name: mpc_wbuf

Overview:
- Parametrised multi-channel write buffer for the multi-port cache.
- Holds store data from N channels until the bank pipeline consumes it, and hands out the wbuffer_id carried in bank requests.
- Generalises the fixed 128-bit / 4-channel store path to configurable channel count, data width and depth.
- Adds round-robin allocation arbitration, registered readout and explicit release.

Parameters:
- CHANNELS, 4, number of requesting channels (≥1)
- DATA_W, 128, store data width in bits
- DEPTH, 32, number of entries (power of 2, ≥2); matches wbufSize
- ID_W, $clog2(DEPTH), entry index width (derived; not overridden)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- alloc_valid_i  in  CHANNELS  per-channel store-allocation request
- alloc_wdata_i  in  CHANNELS*DATA_W  per-channel store data; channel c at bits [c*DATA_W +: DATA_W]
- alloc_ready_o  out  CHANNELS  one-hot grant; a channel's request is accepted when its valid and ready are both high
- alloc_id_o  out  ID_W  entry index assigned to the granted channel; valid while any alloc_ready_o bit is high
- rd_valid_i  in  1  read request
- rd_id_i  in  ID_W  entry to read
- rd_valid_o  out  1  read data valid; asserted one cycle after rd_valid_i
- rd_data_o  out  DATA_W  read data
- rel_valid_i  in  1  release request
- rel_id_i  in  ID_W  entry to free
- free_cnt_o  out  ID_W+1  number of free entries (registered)
- full_o  out  1  high when free_cnt_o == 0

Behaviour:
- State per entry: busy bit and DATA_W data. Reset: all busy=0, RR pointer=0, free_cnt_o=DEPTH, full_o=0, rd_valid_o=0, rd_data_o=0. Data array is not reset.
- Arbitration: among channels with alloc_valid_i=1, winner is the first found scanning from RR pointer upward, wrapping modulo CHANNELS.
- alloc_ready_o[winner]=1 only if at least one entry is free at the start of the cycle. At most one grant per cycle; alloc_ready_o is combinational from registered state and inputs.
- On grant, RR pointer becomes (winner+1) mod CHANNELS. With no grant the pointer holds. Full blocks grants and freezes the pointer.
- alloc_id_o is the lowest-index free entry. On a grant at the clock edge: busy[id]<=1 and data[id]<=the winner's wdata.
- Release: on rel_valid_i at the edge, busy[rel_id_i]<=0. A released entry is not allocatable in the same cycle; it becomes available next cycle.
- Releasing an entry that is already free is ignored: no state change, no count change.
- Read: rd_data_o <= data[rd_id_i] and rd_valid_o <= rd_valid_i, giving 1-cycle latency. Reading an entry released in the same cycle returns the pre-release data. Reading a free entry returns stale data without error unless MPC_WBUF_ERR_EN is defined.
- free_cnt_o <= free_cnt_o − grant + effective_release, where effective_release means a release of a busy entry. A simultaneous grant and release leaves the count unchanged. The count never wraps.
- Reset asserted mid-operation: all outputs and state return to reset values immediately (asynchronous); pending reads are dropped.

Optional Feature:
- Macro MPC_WBUF_ERR_EN.
- Defined: adds output err_o (1 bit, reset 0), registered and pulsed for one cycle when either:
  - rel_valid_i targets an entry that is not busy, or
  - rd_valid_i targets an entry that is not busy.
  Functional behaviour is otherwise identical.
- Not defined: port err_o is absent and these conditions are silently ignored as described above.

Test Plan:
- Reset, then channel 2 alone requests with wdata=0xA5..A5 → alloc_ready_o=4'b0100, alloc_id_o=0. Next cycle free_cnt_o=31. Read id 0 → rd_valid_o=1 one cycle later with rd_data_o=0xA5..A5.
- All 4 channels request continuously for 8 cycles → grants in order ch0,1,2,3,0,1,2,3 with ids 0..7; free_cnt_o=24.
- Fill all 32 entries → full_o=1, alloc_ready_o=0 while requests are held. Release id 5 → next cycle a grant returns alloc_id_o=5 and full_o stays 0 for that cycle only.
- Same cycle: grant to id 3 and release of id 1 → free_cnt_o unchanged. Following cycle, the next allocation returns id 1.
- Release of an already-free id 9 → free_cnt_o unchanged. With MPC_WBUF_ERR_EN defined, err_o=1 for exactly one cycle.
- Assert rst_i for half a cycle while 10 entries are busy and a read is in flight → free_cnt_o=32 and rd_valid_o=0 immediately. The first post-reset grant goes to ch0 with id 0.
